// File: rtl/usart_pkg.sv
// Shared USART definitions: receiver state encoding, frame size and the
// smallest bit period the receiver can time reliably.
package usart_pkg;

  // Receiver frame states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  localparam int USART_DATA_BITS   = 8;
  localparam int USART_MIN_DIVIDER = 4;

  // Bits needed to index a data bit within a frame
  localparam int USART_IDX_W = $clog2(USART_DATA_BITS);

endpackage

// File: rtl/usart_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// RESET_VALUE lets idle-high lines (serial rx) come out of reset idle.
module usart_sync #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Metastability stage followed by the output stage
  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/usart_rx.sv
// 8N1 asynchronous receiver. Finds the start edge, samples each bit at its
// centre using a runtime divider and hands bytes to a valid/ready consumer
// through a single holding register.
module usart_rx
  import usart_pkg::*;
#(
  parameter int DIVIDER_WIDTH = 12
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [DIVIDER_WIDTH-1:0] clock_divider,
  input  logic                     rx_pin,
  output logic [7:0]               data_out,
  output logic                     data_valid,
  input  logic                     data_ready,
  output logic                     framing_error,
  output logic                     overrun_error,
  output logic                     busy
);

  localparam logic [DIVIDER_WIDTH-1:0] MIN_DIV  = DIVIDER_WIDTH'(USART_MIN_DIVIDER);
  localparam logic [USART_IDX_W-1:0]   LAST_IDX = USART_IDX_W'(USART_DATA_BITS - 1);

  rx_state_t                  state;
  logic                       rx_sync;
  logic [DIVIDER_WIDTH-1:0]   div_q;
  logic [DIVIDER_WIDTH-1:0]   div_eff;
  logic [DIVIDER_WIDTH-1:0]   cnt;
  logic [USART_IDX_W-1:0]     bit_idx;
  logic [USART_DATA_BITS-1:0] shreg;

  usart_sync #(.RESET_VALUE(1'b1)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (rx_pin),
    .q     (rx_sync)
  );

  // Out-of-range dividers are clamped so the counters always terminate;
  // bit timing is then wrong but the FSM can never stall.
  always_comb begin
    div_eff = clock_divider;
    if (clock_divider < MIN_DIV) div_eff = MIN_DIV;
  end

  // Frame FSM plus holding register; counters load period-1 so that a
  // sample falls exactly one period after the previous one.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      div_q         <= '0;
      cnt           <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      data_out      <= '0;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
      busy          <= 1'b0;
    end else begin
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
      if (data_valid && data_ready) data_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (!rx_sync) begin
            // Divider is frozen for the whole frame
            div_q <= div_eff;
            cnt   <= (div_eff >> 1) - 1'b1;
            state <= START;
            busy  <= 1'b1;
          end
        end

        START: begin
          if (cnt == '0) begin
            if (rx_sync) begin
              // Line went back high before mid-start: noise, not a frame
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              cnt     <= div_q - 1'b1;
              bit_idx <= '0;
              state   <= DATA;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        DATA: begin
          if (cnt == '0) begin
            shreg[bit_idx] <= rx_sync;
            cnt            <= div_q - 1'b1;
            if (bit_idx == LAST_IDX) state <= STOP;
            else                     bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        STOP: begin
          if (cnt == '0) begin
            if (rx_sync) begin
              // Return to IDLE at the stop centre so a following start
              // edge half a bit later is not missed
              state <= IDLE;
              busy  <= 1'b0;
              if (!data_valid || data_ready) begin
                data_out   <= shreg;
                data_valid <= 1'b1;
              end else begin
                overrun_error <= 1'b1;
              end
            end else begin
              framing_error <= 1'b1;
              state         <= BREAK;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        BREAK: begin
          // Held-low line: one framing error only, wait for idle
          if (rx_sync) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usart_rx.sv
// Directed bench for usart_rx: bytes expected are queued as frames are sent
// and compared when the receiver hands them over.
module tb_usart_rx;

  localparam int DIV = 64;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] clock_divider;
  logic        rx_pin;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        data_ready;
  logic        framing_error;
  logic        overrun_error;
  logic        busy;

  usart_rx #(.DIVIDER_WIDTH(12)) dut (
    .clock         (clock),
    .reset         (reset),
    .clock_divider (clock_divider),
    .rx_pin        (rx_pin),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .data_ready    (data_ready),
    .framing_error (framing_error),
    .overrun_error (overrun_error),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int fe_cnt = 0, ov_cnt = 0, xfer_cnt = 0, dv_cycles = 0;
  int rise_cyc = 0;
  logic dv_prev = 1'b0;
  logic [7:0] exp_q[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: count pulses and compare each transfer
  always @(negedge clock) begin
    if (!reset) begin
      if (framing_error) fe_cnt++;
      if (overrun_error) ov_cnt++;
      if (data_valid) dv_cycles++;
      if (data_valid && !dv_prev) rise_cyc = cyc;
      if (data_valid && data_ready) begin
        xfer_cnt++;
        chk("xfer_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("xfer_data", 32'(data_out), 32'(exp_q.pop_front()));
      end
    end
    dv_prev = data_valid;
  end

  task automatic hold(input logic v, input int n);
    rx_pin = v;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    hold(1'b0, DIV);
    for (int i = 0; i < 8; i++) hold(b[i], DIV);
    hold(stop_bit, DIV);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int fall, fe0, ov0, xf0, dv0;
    reset = 1'b1;
    rx_pin = 1'b1;
    data_ready = 1'b1;
    clock_divider = 12'(DIV);
    repeat (3) @(posedge clock);
    #1;
    chk("rst_data_out", 32'(data_out), 32'h00);
    chk("rst_valid", 32'(data_valid), 32'd0);
    chk("rst_fe", 32'(framing_error), 32'd0);
    chk("rst_ov", 32'(overrun_error), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    hold(1'b1, 10);

    // Single frame 0x75
    fe0 = fe_cnt; ov0 = ov_cnt; xf0 = xfer_cnt; dv0 = dv_cycles;
    exp_q.push_back(8'h75);
    fall = cyc;
    send_frame(8'h75, 1'b1);
    hold(1'b1, 50);
    chk("t1_xfers", 32'(xfer_cnt - xf0), 32'd1);
    chk("t1_valid_cycles", 32'(dv_cycles - dv0), 32'd1);
    chk("t1_latency", 32'((rise_cyc - fall) >= 610 && (rise_cyc - fall) <= 612), 32'd1);
    chk("t1_no_fe", 32'(fe_cnt - fe0), 32'd0);
    chk("t1_no_ov", 32'(ov_cnt - ov0), 32'd0);

    // Second frame 50 cycles after the first stop bit
    exp_q.push_back(8'h8A);
    send_frame(8'h8A, 1'b1);
    hold(1'b1, 20);
    chk("t2_xfers", 32'(xfer_cnt - xf0), 32'd2);
    chk("t2_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("t2_no_ov", 32'(ov_cnt - ov0), 32'd0);

    // Overrun: consumer stalled across two frames
    data_ready = 1'b0;
    ov0 = ov_cnt; xf0 = xfer_cnt;
    exp_q.push_back(8'h75);
    send_frame(8'h75, 1'b1);
    hold(1'b1, 50);
    send_frame(8'h8A, 1'b1);
    hold(1'b1, 20);
    chk("t3_ov_pulse", 32'(ov_cnt - ov0), 32'd1);
    chk("t3_no_xfer", 32'(xfer_cnt - xf0), 32'd0);
    chk("t3_valid_held", 32'(data_valid), 32'd1);
    chk("t3_old_byte", 32'(data_out), 32'h75);
    data_ready = 1'b1;
    hold(1'b1, 3);
    chk("t3_one_xfer", 32'(xfer_cnt - xf0), 32'd1);
    chk("t3_valid_clear", 32'(data_valid), 32'd0);

    // Framing error then line held low
    fe0 = fe_cnt; xf0 = xfer_cnt;
    send_frame(8'h33, 1'b0);
    hold(1'b0, 2000);
    chk("t4_fe_once", 32'(fe_cnt - fe0), 32'd1);
    chk("t4_busy_low_line", 32'(busy), 32'd1);
    chk("t4_no_xfer", 32'(xfer_cnt - xf0), 32'd0);
    hold(1'b1, 5);
    chk("t4_busy_released", 32'(busy), 32'd0);
    chk("t4_fe_still_once", 32'(fe_cnt - fe0), 32'd1);

    // 20-cycle glitch rejected at the start sample
    fe0 = fe_cnt; ov0 = ov_cnt; dv0 = dv_cycles;
    hold(1'b0, 10);
    chk("t5_busy_start", 32'(busy), 32'd1);
    hold(1'b0, 10);
    hold(1'b1, 15);
    chk("t5_busy_idle", 32'(busy), 32'd0);
    hold(1'b1, 20);
    chk("t5_no_valid", 32'(dv_cycles - dv0), 32'd0);
    chk("t5_no_err", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 32'd0);

    // Reset mid-DATA abandons the frame
    xf0 = xfer_cnt; fe0 = fe_cnt;
    hold(1'b0, DIV);
    hold(1'b1, DIV);
    hold(1'b0, DIV);
    reset = 1'b1;
    rx_pin = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_valid", 32'(data_valid), 32'd0);
    chk("t6_rst_data", 32'(data_out), 32'h00);
    chk("t6_rst_flags", 32'({framing_error, overrun_error}), 32'd0);
    reset = 1'b0;
    hold(1'b1, 10);
    exp_q.push_back(8'h8A);
    send_frame(8'h8A, 1'b1);
    hold(1'b1, 20);
    chk("t6_one_xfer", 32'(xfer_cnt - xf0), 32'd1);
    chk("t6_no_fe", 32'(fe_cnt - fe0), 32'd0);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
